// File: rtl/muldiv_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the M-extension issue controller:
//   - field width macros used on the controller and bus ports
//   - RV32M opcode/funct7/funct3 constants
//   - controller state enum
//   - latched request record
//   - is_muldiv() decode helper
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif
`ifndef FUNCT7_WIDTH
`define FUNCT7_WIDTH 7
`endif

package muldiv_pkg;

    // Widths of the latched request record; the controller parameters default
    // to these and must stay equal to them.
    localparam int MD_XLEN     = 32;
    localparam int MD_RD_WIDTH = 5;

    localparam logic [`OPCODE_WIDTH-1:0] OP_OP         = 7'b0110011;
    localparam logic [`FUNCT7_WIDTH-1:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [`FUNCT3_WIDTH-1:0] FUNCT3_MUL    = 3'b000;
    localparam logic [`FUNCT3_WIDTH-1:0] FUNCT3_MULH   = 3'b001;
    localparam logic [`FUNCT3_WIDTH-1:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [`FUNCT3_WIDTH-1:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [`FUNCT3_WIDTH-1:0] FUNCT3_DIV    = 3'b100;
    localparam logic [`FUNCT3_WIDTH-1:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [`FUNCT3_WIDTH-1:0] FUNCT3_REM    = 3'b110;
    localparam logic [`FUNCT3_WIDTH-1:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } muldiv_issue_state_t;

    typedef struct packed {
        logic [`FUNCT3_WIDTH-1:0] funct3;
        logic [MD_XLEN-1:0]       rs0;
        logic [MD_XLEN-1:0]       rs1;
        logic [MD_RD_WIDTH-1:0]   rd;
    } muldiv_req_t;

    function automatic logic is_muldiv(input logic [`OPCODE_WIDTH-1:0] opcode,
                                       input logic [`FUNCT7_WIDTH-1:0] funct7);
        return (opcode == OP_OP) && (funct7 == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_issue_ctrl_if
// Request/response bus between the issue controller and the mul/div unit.
//   req_valid  : controller -> unit, request present
//   req_ready  : unit -> controller, request accepted this cycle
//   req_funct3 : operation select
//   req_rs0/1  : operands
//   rsp_stb    : unit -> controller, one-cycle result strobe
//   rsp_data   : result value
// Modports: master (controller side), slave (unit side).
// -----------------------------------------------------------------------------
interface muldiv_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic [`FUNCT3_WIDTH-1:0] req_funct3;
    logic [XLEN-1:0]          req_rs0;
    logic [XLEN-1:0]          req_rs1;
    logic                     rsp_stb;
    logic [XLEN-1:0]          rsp_data;

    modport master (
        output req_valid,
        output req_funct3,
        output req_rs0,
        output req_rs1,
        input  req_ready,
        input  rsp_stb,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_funct3,
        input  req_rs0,
        input  req_rs1,
        output req_ready,
        output rsp_stb,
        output rsp_data
    );
endinterface

// File: rtl/muldiv_issue_ctrl_result_cache.sv
// -----------------------------------------------------------------------------
// muldiv_result_cache
// Single-entry memo of the last unflushed mul/div result.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   lookup_*_i            : operation/operands of the instruction in EX
//   hit_o, hit_data_o     : entry valid and matching, and its stored result
//   wr_en_i, wr_*_i       : load the entry with a completed operation
// The valid bit is only ever cleared by reset.
// -----------------------------------------------------------------------------
module muldiv_result_cache
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [`FUNCT3_WIDTH-1:0] lookup_funct3_i,
    input  logic [XLEN-1:0]          lookup_rs0_i,
    input  logic [XLEN-1:0]          lookup_rs1_i,
    output logic                     hit_o,
    output logic [XLEN-1:0]          hit_data_o,
    input  logic                     wr_en_i,
    input  logic [`FUNCT3_WIDTH-1:0] wr_funct3_i,
    input  logic [XLEN-1:0]          wr_rs0_i,
    input  logic [XLEN-1:0]          wr_rs1_i,
    input  logic [XLEN-1:0]          wr_data_i
);
    logic                     valid_q,  valid_d;
    logic [`FUNCT3_WIDTH-1:0] funct3_q, funct3_d;
    logic [XLEN-1:0]          rs0_q,    rs0_d;
    logic [XLEN-1:0]          rs1_q,    rs1_d;
    logic [XLEN-1:0]          result_q, result_d;

    always_comb begin
        valid_d  = valid_q;
        funct3_d = funct3_q;
        rs0_d    = rs0_q;
        rs1_d    = rs1_q;
        result_d = result_q;
        if (wr_en_i) begin
            valid_d  = 1'b1;
            funct3_d = wr_funct3_i;
            rs0_d    = wr_rs0_i;
            rs1_d    = wr_rs1_i;
            result_d = wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            funct3_q <= '0;
            rs0_q    <= '0;
            rs1_q    <= '0;
            result_q <= '0;
        end else begin
            valid_q  <= valid_d;
            funct3_q <= funct3_d;
            rs0_q    <= rs0_d;
            rs1_q    <= rs1_d;
            result_q <= result_d;
        end
    end

    assign hit_o = valid_q
                 & (funct3_q == lookup_funct3_i)
                 & (rs0_q    == lookup_rs0_i)
                 & (rs1_q    == lookup_rs1_i);
    assign hit_data_o = result_q;

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_issue_ctrl
// EX-stage initiator for the multi-cycle RV32M unit. Detects an M instruction,
// stalls the pipeline, issues one request over md_bus, waits for the result
// strobe and returns a one-cycle writeback. A flush after the request was
// accepted leaves the controller draining the in-flight response.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   ex_valid_i, opcode_i,
//   funct3_i, funct7_i      : EX instruction and its decode fields
//   rs0_i, rs1_i, rd_i      : operands and destination register
//   flush_i                 : kill the current EX instruction
//   stall_o                 : hold IF/ID/EX
//   md_bus (master)         : request/response bus to the mul/div unit
//   wb_valid_o/rd_o/data_o  : one-cycle writeback, data held while not valid
// Build option:
//   MULDIV_RESULT_CACHE_EN  : single-entry result cache; a repeated identical
//                             M instruction writes back without a request.
// -----------------------------------------------------------------------------
module muldiv_issue_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN     = MD_XLEN,
    parameter int RD_WIDTH = MD_RD_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ex_valid_i,
    input  logic [`OPCODE_WIDTH-1:0] opcode_i,
    input  logic [`FUNCT3_WIDTH-1:0] funct3_i,
    input  logic [`FUNCT7_WIDTH-1:0] funct7_i,
    input  logic [XLEN-1:0]          rs0_i,
    input  logic [XLEN-1:0]          rs1_i,
    input  logic [RD_WIDTH-1:0]      rd_i,
    input  logic                     flush_i,
    output logic                     stall_o,
    muldiv_issue_ctrl_if.master      md_bus,
    output logic                     wb_valid_o,
    output logic [RD_WIDTH-1:0]      wb_rd_o,
    output logic [XLEN-1:0]          wb_data_o
);
    muldiv_issue_state_t state_q, state_d;
    muldiv_req_t         req_q,   req_d;
    logic [RD_WIDTH-1:0] wb_rd_q,   wb_rd_d;
    logic [XLEN-1:0]     wb_data_q, wb_data_d;

    logic            is_md;
    logic            accept;
    logic            handshake;
    logic            stall;
    logic            req_valid;
    logic            wb_valid;
    logic            cache_hit;
    logic [XLEN-1:0] cache_data;

    assign is_md     = ex_valid_i & is_muldiv(opcode_i, funct7_i);
    assign accept    = is_md & ~flush_i;
    assign handshake = (state_q == ST_ISSUE) & md_bus.req_ready;

`ifdef MULDIV_RESULT_CACHE_EN
    logic cache_wr;

    muldiv_result_cache #(
        .XLEN (XLEN)
    ) u_cache (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lookup_funct3_i (funct3_i),
        .lookup_rs0_i    (rs0_i),
        .lookup_rs1_i    (rs1_i),
        .hit_o           (cache_hit),
        .hit_data_o      (cache_data),
        .wr_en_i         (cache_wr),
        .wr_funct3_i     (req_q.funct3),
        .wr_rs0_i        (req_q.rs0),
        .wr_rs1_i        (req_q.rs1),
        .wr_data_i       (md_bus.rsp_data)
    );

    // Only a result that is actually written back is worth remembering.
    assign cache_wr = (state_q == ST_WAIT) & md_bus.rsp_stb & ~flush_i;
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    // Next-state and output decode. The writeback registers are loaded on the
    // way into DONE so that wb_rd_o/wb_data_o keep their value afterwards.
    // A flush in WAIT or together with the handshake leaves a response in
    // flight, which DRAIN absorbs before a new request may go out.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        stall     = 1'b0;
        req_valid = 1'b0;
        wb_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall = accept;
                if (accept) begin
                    req_d = '{funct3: funct3_i, rs0: rs0_i, rs1: rs1_i, rd: rd_i};
                    if (cache_hit) begin
                        wb_rd_d   = rd_i;
                        wb_data_d = cache_data;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                stall     = 1'b1;
                req_valid = 1'b1;
                if (handshake) begin
                    state_d = flush_i ? ST_DRAIN : ST_WAIT;
                end else if (flush_i) begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT: begin
                stall = 1'b1;
                if (md_bus.rsp_stb) begin
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        wb_rd_d   = req_q.rd;
                        wb_data_d = md_bus.rsp_data;
                        state_d   = ST_DONE;
                    end
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                stall = is_md;
                if (md_bus.rsp_stb) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                wb_valid = ~flush_i;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // The strobes are masked during reset so that a combinational detect in
    // the reset cycle cannot leak out as a stall or request.
    assign stall_o           = stall & ~rst_i;
    assign md_bus.req_valid  = req_valid & ~rst_i;
    assign md_bus.req_funct3 = req_q.funct3;
    assign md_bus.req_rs0    = req_q.rs0;
    assign md_bus.req_rs1    = req_q.rs1;
    assign wb_valid_o        = wb_valid & ~rst_i;
    assign wb_rd_o           = wb_rd_q;
    assign wb_data_o         = wb_data_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_issue_ctrl
// Directed scoreboard bench for muldiv_issue_ctrl. Stimulus pushes expected
// requests and writebacks into queues; a monitor process compares whatever
// the DUT presents on the request bus and on the writeback port.
// Cache checks are compiled when MULDIV_RESULT_CACHE_EN is defined.
// -----------------------------------------------------------------------------
module tb_muldiv_issue_ctrl;
    import muldiv_pkg::*;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
    } req_exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] rs0_i;
    logic [31:0] rs1_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    muldiv_issue_ctrl_if #(.XLEN(32)) md_bus ();

    muldiv_issue_ctrl #(
        .XLEN     (32),
        .RD_WIDTH (5)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ex_valid_i (ex_valid_i),
        .opcode_i   (opcode_i),
        .funct3_i   (funct3_i),
        .funct7_i   (funct7_i),
        .rs0_i      (rs0_i),
        .rs1_i      (rs1_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .md_bus     (md_bus),
        .wb_valid_o (wb_valid_o),
        .wb_rd_o    (wb_rd_o),
        .wb_data_o  (wb_data_o)
    );

    always #5 clk_i = ~clk_i;

    req_exp_t exp_req_q[$];
    wb_exp_t  exp_wb_q[$];

    int tests_run     = 0;
    int tests_failed  = 0;
    int hs_count      = 0;
    int wb_count      = 0;
    int stall_count   = 0;
    int cycle         = 0;
    int last_wb_cycle = 0;
    int detect_cycle  = 0;
    bit ok;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
        ex_valid_i = 1'b1;
        opcode_i   = OP_OP;
        funct7_i   = FUNCT7_MULDIV;
        funct3_i   = f3;
        rs0_i      = a;
        rs1_i      = b;
        rd_i       = rd;
    endtask

    task automatic clearStimulus();
        ex_valid_i = 1'b0;
    endtask

    task automatic clear_counts();
        hs_count    = 0;
        wb_count    = 0;
        stall_count = 0;
    endtask

    task automatic wait_handshake(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (md_bus.req_valid && md_bus.req_ready) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wb(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (wb_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Full non-flushed operation: ready high, result one cycle after handshake.
    task automatic run_normal(input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd,
                              input logic [31:0] result, input string name);
        bit seen;
        md_bus.req_ready = 1'b1;
        exp_req_q.push_back('{f3, a, b});
        exp_wb_q.push_back('{rd, result});
        applyStimulus(f3, a, b, rd);
        wait_handshake(seen);
        checkOutput({name, "_hs_seen"}, 64'(seen), 64'd1);
        tick();
        md_bus.rsp_stb  = 1'b1;
        md_bus.rsp_data = result;
        tick();
        md_bus.rsp_stb = 1'b0;
        wait_wb(seen);
        checkOutput({name, "_wb_seen"}, 64'(seen), 64'd1);
        tick();
        clearStimulus();
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            cycle++;
        end
    end

    // Scoreboard monitor: request fields are compared every cycle the request
    // is presented, so they must be stable until the handshake pops them.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (stall_o) stall_count++;
                if (md_bus.req_valid) begin
                    if (exp_req_q.size() == 0) begin
                        checkOutput("req_unexpected", 64'(md_bus.req_valid), 64'd0);
                    end else begin
                        checkOutput("req_funct3", 64'(md_bus.req_funct3), 64'(exp_req_q[0].f3));
                        checkOutput("req_rs0", 64'(md_bus.req_rs0), 64'(exp_req_q[0].a));
                        checkOutput("req_rs1", 64'(md_bus.req_rs1), 64'(exp_req_q[0].b));
                        if (md_bus.req_ready) void'(exp_req_q.pop_front());
                    end
                    if (md_bus.req_ready) hs_count++;
                end
                if (wb_valid_o) begin
                    wb_count++;
                    last_wb_cycle = cycle;
                    if (exp_wb_q.size() == 0) begin
                        checkOutput("wb_unexpected", 64'(wb_valid_o), 64'd0);
                    end else begin
                        e = exp_wb_q.pop_front();
                        checkOutput("wb_rd", 64'(wb_rd_o), 64'(e.rd));
                        checkOutput("wb_data", 64'(wb_data_o), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_i           = 1'b1;
        ex_valid_i      = 1'b0;
        flush_i         = 1'b0;
        opcode_i        = '0;
        funct3_i        = '0;
        funct7_i        = '0;
        rs0_i           = '0;
        rs1_i           = '0;
        rd_i            = '0;
        md_bus.req_ready = 1'b0;
        md_bus.rsp_stb   = 1'b0;
        md_bus.rsp_data  = '0;

        repeat (3) tick();
        @(negedge clk_i);
        checkOutput("rst_stall", 64'(stall_o), 64'd0);
        checkOutput("rst_req_valid", 64'(md_bus.req_valid), 64'd0);
        checkOutput("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        checkOutput("rst_wb_rd", 64'(wb_rd_o), 64'd0);
        checkOutput("rst_wb_data", 64'(wb_data_o), 64'd0);
        checkOutput("rst_req_rs0", 64'(md_bus.req_rs0), 64'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // MUL 7*6, ready high, result strobed 4 cycles after the handshake.
        clear_counts();
        md_bus.req_ready = 1'b1;
        applyStimulus(FUNCT3_MUL, 32'd7, 32'd6, 5'd5);
        detect_cycle = cycle;
        exp_req_q.push_back('{FUNCT3_MUL, 32'd7, 32'd6});
        exp_wb_q.push_back('{5'd5, 32'd42});
        wait_handshake(ok);
        checkOutput("t1_hs_seen", 64'(ok), 64'd1);
        repeat (4) tick();
        md_bus.rsp_stb  = 1'b1;
        md_bus.rsp_data = 32'd42;
        tick();
        md_bus.rsp_stb = 1'b0;
        wait_wb(ok);
        checkOutput("t1_wb_seen", 64'(ok), 64'd1);
        tick();
        clearStimulus();
        checkOutput("t1_latency", 64'(last_wb_cycle - detect_cycle), 64'd6);
        checkOutput("t1_stall_cycles", 64'(stall_count), 64'd6);
        checkOutput("t1_hs_count", 64'(hs_count), 64'd1);
        checkOutput("t1_wb_count", 64'(wb_count), 64'd1);
        tick();

        // DIVU 100/7 with ready held low for three ISSUE cycles.
        clear_counts();
        md_bus.req_ready = 1'b0;
        applyStimulus(FUNCT3_DIVU, 32'd100, 32'd7, 5'd3);
        exp_req_q.push_back('{FUNCT3_DIVU, 32'd100, 32'd7});
        exp_wb_q.push_back('{5'd3, 32'd14});
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput("t2_req_held", 64'(md_bus.req_valid), 64'd1);
            checkOutput("t2_stall_held", 64'(stall_o), 64'd1);
            tick();
        end
        md_bus.req_ready = 1'b1;
        wait_handshake(ok);
        checkOutput("t2_hs_seen", 64'(ok), 64'd1);
        tick();
        md_bus.rsp_stb  = 1'b1;
        md_bus.rsp_data = 32'd14;
        tick();
        md_bus.rsp_stb = 1'b0;
        wait_wb(ok);
        checkOutput("t2_wb_seen", 64'(ok), 64'd1);
        tick();
        clearStimulus();
        checkOutput("t2_hs_count", 64'(hs_count), 64'd1);
        tick();

        // REM -9,4 flushed in WAIT; DRAIN holds off a new MUL 3*3 until the
        // stale 0xFFFFFFFF response has been swallowed.
        clear_counts();
        md_bus.req_ready = 1'b1;
        applyStimulus(FUNCT3_REM, 32'hFFFF_FFF7, 32'd4, 5'd7);
        exp_req_q.push_back('{FUNCT3_REM, 32'hFFFF_FFF7, 32'd4});
        wait_handshake(ok);
        checkOutput("t3_hs_seen", 64'(ok), 64'd1);
        tick();
        flush_i = 1'b1;
        @(negedge clk_i);
        checkOutput("t3_stall_wait_flush", 64'(stall_o), 64'd1);
        tick();
        flush_i = 1'b0;
        clearStimulus();
        @(negedge clk_i);
        checkOutput("t3_stall_drain", 64'(stall_o), 64'd0);
        tick();
        applyStimulus(FUNCT3_MUL, 32'd3, 32'd3, 5'd6);
        @(negedge clk_i);
        checkOutput("t3_drain_holdoff", 64'(stall_o), 64'd1);
        checkOutput("t3_drain_no_req", 64'(md_bus.req_valid), 64'd0);
        tick();
        md_bus.rsp_stb  = 1'b1;
        md_bus.rsp_data = 32'hFFFF_FFFF;
        tick();
        md_bus.rsp_stb = 1'b0;
        exp_req_q.push_back('{FUNCT3_MUL, 32'd3, 32'd3});
        exp_wb_q.push_back('{5'd6, 32'd9});
        wait_handshake(ok);
        checkOutput("t3_new_hs_seen", 64'(ok), 64'd1);
        tick();
        md_bus.rsp_stb  = 1'b1;
        md_bus.rsp_data = 32'd9;
        tick();
        md_bus.rsp_stb = 1'b0;
        wait_wb(ok);
        checkOutput("t3_wb_seen", 64'(ok), 64'd1);
        tick();
        clearStimulus();
        checkOutput("t3_wb_count", 64'(wb_count), 64'd1);
        checkOutput("t3_hs_count", 64'(hs_count), 64'd2);
        tick();

        // DIV 20/5 flushed in WAIT together with the strobe: straight to IDLE,
        // so a following MUL 2*8 issues a request on the very next cycle.
        clear_counts();
        md_bus.req_ready = 1'b1;
        applyStimulus(FUNCT3_DIV, 32'd20, 32'd5, 5'd9);
        exp_req_q.push_back('{FUNCT3_DIV, 32'd20, 32'd5});
        wait_handshake(ok);
        checkOutput("t3b_hs_seen", 64'(ok), 64'd1);
        tick();
        flush_i         = 1'b1;
        md_bus.rsp_stb  = 1'b1;
        md_bus.rsp_data = 32'd4;
        tick();
        flush_i          = 1'b0;
        md_bus.rsp_stb   = 1'b0;
        md_bus.req_ready = 1'b0;
        applyStimulus(FUNCT3_MUL, 32'd2, 32'd8, 5'd4);
        exp_req_q.push_back('{FUNCT3_MUL, 32'd2, 32'd8});
        exp_wb_q.push_back('{5'd4, 32'd16});
        tick();
        @(negedge clk_i);
        checkOutput("t3b_reissue", 64'(md_bus.req_valid), 64'd1);
        tick();
        md_bus.req_ready = 1'b1;
        wait_handshake(ok);
        checkOutput("t3b_new_hs_seen", 64'(ok), 64'd1);
        tick();
        md_bus.rsp_stb  = 1'b1;
        md_bus.rsp_data = 32'd16;
        tick();
        md_bus.rsp_stb = 1'b0;
        wait_wb(ok);
        checkOutput("t3b_wb_seen", 64'(ok), 64'd1);
        tick();
        clearStimulus();
        checkOutput("t3b_wb_count", 64'(wb_count), 64'd1);
        tick();

        // MULH flushed in ISSUE before ready: request withdrawn, nothing else.
        clear_counts();
        md_bus.req_ready = 1'b0;
        applyStimulus(FUNCT3_MULH, 32'd11, 32'd13, 5'd2);
        exp_req_q.push_back('{FUNCT3_MULH, 32'd11, 32'd13});
        tick();
        flush_i = 1'b1;
        @(negedge clk_i);
        checkOutput("t4_req_before_flush", 64'(md_bus.req_valid), 64'd1);
        tick();
        flush_i = 1'b0;
        clearStimulus();
        @(negedge clk_i);
        checkOutput("t4_req_dropped", 64'(md_bus.req_valid), 64'd0);
        checkOutput("t4_stall_dropped", 64'(stall_o), 64'd0);
        exp_req_q.delete();
        tick();
        md_bus.req_ready = 1'b1;
        repeat (4) tick();
        checkOutput("t4_hs_count", 64'(hs_count), 64'd0);
        checkOutput("t4_wb_count", 64'(wb_count), 64'd0);

        // Reset in WAIT: everything back to zero, stale strobe ignored.
        clear_counts();
        applyStimulus(FUNCT3_MULHSU, 32'd5, 32'd6, 5'd8);
        exp_req_q.push_back('{FUNCT3_MULHSU, 32'd5, 32'd6});
        wait_handshake(ok);
        checkOutput("t5_hs_seen", 64'(ok), 64'd1);
        tick();
        tick();
        rst_i = 1'b1;
        clearStimulus();
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("t5_stall", 64'(stall_o), 64'd0);
        checkOutput("t5_req_valid", 64'(md_bus.req_valid), 64'd0);
        checkOutput("t5_wb_valid", 64'(wb_valid_o), 64'd0);
        checkOutput("t5_wb_rd", 64'(wb_rd_o), 64'd0);
        checkOutput("t5_wb_data", 64'(wb_data_o), 64'd0);
        checkOutput("t5_req_funct3", 64'(md_bus.req_funct3), 64'd0);
        checkOutput("t5_req_rs0", 64'(md_bus.req_rs0), 64'd0);
        checkOutput("t5_req_rs1", 64'(md_bus.req_rs1), 64'd0);
        tick();
        md_bus.rsp_stb  = 1'b1;
        md_bus.rsp_data = 32'd123;
        tick();
        md_bus.rsp_stb = 1'b0;
        repeat (3) tick();
        checkOutput("t5_wb_count", 64'(wb_count), 64'd0);

`ifdef MULDIV_RESULT_CACHE_EN
        // MULHU 0xFFFFFFFF*2 = 1 (high word); the identical repeat must hit.
        clear_counts();
        run_normal(FUNCT3_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd10, 32'd1, "t6_fill");
        tick();
        clear_counts();
        applyStimulus(FUNCT3_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd10);
        exp_wb_q.push_back('{5'd10, 32'd1});
        detect_cycle = cycle;
        @(negedge clk_i);
        checkOutput("t6_hit_stall", 64'(stall_o), 64'd1);
        checkOutput("t6_hit_no_req", 64'(md_bus.req_valid), 64'd0);
        tick();
        @(negedge clk_i);
        checkOutput("t6_hit_wb_valid", 64'(wb_valid_o), 64'd1);
        tick();
        clearStimulus();
        checkOutput("t6_hit_latency", 64'(last_wb_cycle - detect_cycle), 64'd1);
        checkOutput("t6_hit_hs_count", 64'(hs_count), 64'd0);
        tick();
        clear_counts();
        run_normal(FUNCT3_MULHU, 32'hFFFF_FFFF, 32'd3, 5'd11, 32'd2, "t6_miss");
        checkOutput("t6_miss_hs_count", 64'(hs_count), 64'd1);
`else
        // Without the cache an identical repeat still issues its own request.
        clear_counts();
        run_normal(FUNCT3_MUL, 32'd7, 32'd6, 5'd5, 32'd42, "t6_first");
        tick();
        run_normal(FUNCT3_MUL, 32'd7, 32'd6, 5'd5, 32'd42, "t6_repeat");
        checkOutput("t6_hs_count", 64'(hs_count), 64'd2);
        checkOutput("t6_wb_count", 64'(wb_count), 64'd2);
`endif

        repeat (3) tick();
        checkOutput("end_req_queue_empty", 64'(exp_req_q.size()), 64'd0);
        checkOutput("end_wb_queue_empty", 64'(exp_wb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
